// File: rtl/if_id_pipe_pkg.sv
// Shared defaults and FSM state encoding for the IF->ID pipeline register.
// Build option: IF_ID_SKID_EN enables the one-entry skid register (see if_id_pipe.sv).
package pipe_defs;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_INST_W = 32;

    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;
    localparam logic [31:0] DEF_RST_PC   = 32'h0000_0000;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_EMPTY = 2'd0;
    localparam logic [ST_W-1:0] ST_BUSY  = 2'd1;
    localparam logic [ST_W-1:0] ST_FULL  = 2'd2;

endpackage : pipe_defs

// File: rtl/if_id_pipe_if.sv
// Valid/ready channel carrying one {pc, inst} pair.
// The producer uses the master modport and the consumer uses the slave modport.
interface if_id_pipe_if
    import pipe_defs::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned INST_W = DEF_INST_W
);

    logic              valid;
    logic              ready;
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;

    modport master (output valid, output pc, output inst, input ready);
    modport slave  (input valid, input pc, input inst, output ready);

endinterface : if_id_pipe_if

// File: rtl/if_id_pipe_skid_buf.sv
// One-entry skid register: a valid flag plus a data word.
// Clear takes priority over pop and load. The data word is written only on load.
module pipe_skid_buf #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         pop_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Next-state logic for the entry.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clr_i || pop_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
        end
        if (load_i && !clr_i) begin
            data_d = data_i;
        end
    end

    // Entry registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule : pipe_skid_buf

// File: rtl/if_id_pipe.sv
// IF->ID pipeline register with a valid/ready handshake, stall, flush and NOP bubbles.
// Build option: IF_ID_SKID_EN adds a one-entry skid so that in_ready comes from a
// register. The default build is a two-state EMPTY/BUSY register whose in_ready is
// combinational.
module if_id_pipe
    import pipe_defs::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       INST_W   = DEF_INST_W,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEF_NOP_INST),
    parameter logic [ADDR_W-1:0] RST_PC   = ADDR_W'(DEF_RST_PC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    if_id_pipe_if.slave   in_if,
    if_id_pipe_if.master  out_if
);

    logic [ST_W-1:0]   state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;

    logic out_valid_c;
    logic in_ready_c;
    logic accept_c;
    logic consume_c;

`ifdef IF_ID_SKID_EN
    logic                     skid_valid;
    logic [ADDR_W+INST_W-1:0] skid_data;
    logic                     skid_load_c;
    logic                     skid_pop_c;

    // The skid holds the input that was accepted while decode stalled.
    pipe_skid_buf #(
        .W (ADDR_W + INST_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (flush),
        .load_i  (skid_load_c),
        .pop_i   (skid_pop_c),
        .data_i  ({in_if.pc, in_if.inst}),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    // in_ready depends only on the skid flop, so out_ready has no path to it.
    assign in_ready_c = !skid_valid;
`else
    // A free slot is either empty or is being drained this cycle.
    assign in_ready_c = !out_valid_c || out_if.ready;
`endif

    assign out_valid_c = (state_q != ST_EMPTY);
    assign accept_c    = in_if.valid && in_ready_c;
    assign consume_c   = out_valid_c && out_if.ready;

    // Next-state and output-register logic. Flush overrides every transfer.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
`ifdef IF_ID_SKID_EN
        skid_load_c = 1'b0;
        skid_pop_c  = 1'b0;
`endif
        if (flush) begin
            state_d = ST_EMPTY;
            pc_d    = RST_PC;
            inst_d  = NOP_INST;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_c) begin
                        state_d = ST_BUSY;
                        pc_d    = in_if.pc;
                        inst_d  = in_if.inst;
                    end
                end
                ST_BUSY: begin
                    if (consume_c) begin
                        if (accept_c) begin
                            pc_d   = in_if.pc;
                            inst_d = in_if.inst;
                        end else begin
                            state_d = ST_EMPTY;
                            pc_d    = RST_PC;
                            inst_d  = NOP_INST;
                        end
                    end
`ifdef IF_ID_SKID_EN
                    else if (accept_c) begin
                        state_d     = ST_FULL;
                        skid_load_c = 1'b1;
                    end
`endif
                end
`ifdef IF_ID_SKID_EN
                ST_FULL: begin
                    if (consume_c) begin
                        state_d    = ST_BUSY;
                        pc_d       = skid_data[ADDR_W+INST_W-1:INST_W];
                        inst_d     = skid_data[INST_W-1:0];
                        skid_pop_c = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = ST_EMPTY;
                    pc_d    = RST_PC;
                    inst_d  = NOP_INST;
                end
            endcase
        end
    end

    // State and output registers. Reset leaves a clean bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            pc_q    <= RST_PC;
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign in_if.ready  = in_ready_c;
    assign out_if.valid = out_valid_c;
    assign out_if.pc    = pc_q;
    assign out_if.inst  = inst_q;

endmodule : if_id_pipe
